// File: rtl/note_voice_alloc.sv
// note_voice_alloc: decodes note commands arriving from a UART receiver and
// maps them onto a small pool of polyphonic voices with oldest-voice stealing.
module note_voice_alloc #(
  parameter int C_DATA_WIDTH = 8,
  parameter int C_VOICES     = 4,
  parameter int C_NOTE_WIDTH = 7,
  parameter int C_TIMEOUT    = 1_000_000
) (
  input  logic                             clk,
  input  logic                             rstb,
  input  logic                             rxValid,
  output logic                             rxAck,
  input  logic [C_DATA_WIDTH-1:0]          rxData,
  input  logic                             rxErr,
  output logic [C_VOICES-1:0]              voiceOn,
  output logic [C_VOICES*C_NOTE_WIDTH-1:0] voiceNote,
  output logic [C_VOICES-1:0]              voiceTrig,
  output logic                             cmdErr
);

  localparam int RANK_W = (C_VOICES > 1) ? $clog2(C_VOICES) : 1;
  localparam int CNT_W  = $clog2(C_TIMEOUT + 1);

  localparam logic [C_DATA_WIDTH-1:0] ST_NOTE_ON  = C_DATA_WIDTH'(8'h90);
  localparam logic [C_DATA_WIDTH-1:0] ST_NOTE_OFF = C_DATA_WIDTH'(8'h80);
  localparam logic [C_DATA_WIDTH-1:0] ST_ALL_OFF  = C_DATA_WIDTH'(8'hB0);
  localparam logic [CNT_W-1:0]        CNT_LAST    = CNT_W'(C_TIMEOUT - 1);
  localparam logic [RANK_W-1:0]       RANK_OLDEST = RANK_W'(C_VOICES - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_NOTE,
    APPLY
  } state_t;

  typedef enum logic [1:0] {
    OP_ON,
    OP_OFF,
    OP_ALL
  } op_t;

  state_t                  state;
  op_t                     op;
  logic [C_NOTE_WIDTH-1:0] note_q;
  logic [CNT_W-1:0]        cnt;

  logic is_data;
  logic is_on;
  logic is_off;
  logic is_all;

  logic [C_NOTE_WIDTH-1:0] note_arr [C_VOICES];
  logic [RANK_W-1:0]       rank     [C_VOICES];

  logic              hit;
  logic [RANK_W-1:0] hit_idx;
  logic              free_found;
  logic [RANK_W-1:0] free_idx;
  logic [RANK_W-1:0] old_idx;
  logic [RANK_W-1:0] tgt_idx;

  assign is_data = ~rxData[C_DATA_WIDTH-1];
  assign is_on   = (rxData == ST_NOTE_ON);
  assign is_off  = (rxData == ST_NOTE_OFF);
  assign is_all  = (rxData == ST_ALL_OFF);

  // Command FSM: paces the UART handshake, assembles status+data pairs and flags protocol errors.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state  <= IDLE;
      op     <= OP_ON;
      note_q <= '0;
      cnt    <= '0;
      rxAck  <= 1'b0;
      cmdErr <= 1'b0;
    end else begin
      rxAck  <= 1'b0;
      cmdErr <= 1'b0;
      case (state)
        IDLE: begin
          if (rxAck) begin
            if (rxErr) begin
              cmdErr <= 1'b1;
            end else if (is_on || is_off) begin
              op    <= is_on ? OP_ON : OP_OFF;
              cnt   <= '0;
              state <= WAIT_NOTE;
            end else if (is_all) begin
              op    <= OP_ALL;
              state <= APPLY;
            end else begin
              cmdErr <= 1'b1;
            end
          end else if (rxValid) begin
            rxAck <= 1'b1;
          end
        end
        WAIT_NOTE: begin
          if (rxAck) begin
            if (rxErr) begin
              cmdErr <= 1'b1;
              state  <= IDLE;
            end else if (is_data) begin
              note_q <= rxData[C_NOTE_WIDTH-1:0];
              state  <= APPLY;
            end else begin
              cmdErr <= 1'b1;
              if (is_on || is_off) begin
                op    <= is_on ? OP_ON : OP_OFF;
                cnt   <= '0;
                state <= WAIT_NOTE;
              end else if (is_all) begin
                op    <= OP_ALL;
                state <= APPLY;
              end else begin
                state <= IDLE;
              end
            end
          end else if (cnt == CNT_LAST) begin
            cmdErr <= 1'b1;
            cnt    <= '0;
            state  <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (rxValid) begin
              rxAck <= 1'b1;
            end
          end
        end
        APPLY: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Voice selection: lowest voice already holding the note, else lowest free voice, else the oldest.
  always_comb begin
    hit        = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    old_idx    = '0;
    for (int v = C_VOICES - 1; v >= 0; v--) begin
      if (voiceOn[v] && (note_arr[v] == note_q)) begin
        hit     = 1'b1;
        hit_idx = RANK_W'(v);
      end
      if (!voiceOn[v]) begin
        free_found = 1'b1;
        free_idx   = RANK_W'(v);
      end
      if (rank[v] == RANK_OLDEST) begin
        old_idx = RANK_W'(v);
      end
    end
    if (hit) begin
      tgt_idx = hit_idx;
    end else if (free_found) begin
      tgt_idx = free_idx;
    end else begin
      tgt_idx = old_idx;
    end
  end

  // Voice state: applies the latched command during APPLY and keeps the age ranking consistent.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      voiceOn   <= '0;
      voiceTrig <= '0;
      for (int v = 0; v < C_VOICES; v++) begin
        note_arr[v] <= '0;
        rank[v]     <= RANK_W'(v);
      end
    end else begin
      voiceTrig <= '0;
      if (state == APPLY) begin
        case (op)
          OP_ON: begin
            voiceTrig[tgt_idx] <= 1'b1;
            if (!hit) begin
              voiceOn[tgt_idx]  <= 1'b1;
              note_arr[tgt_idx] <= note_q;
              for (int v = 0; v < C_VOICES; v++) begin
                if (rank[v] < rank[tgt_idx]) begin
                  rank[v] <= rank[v] + RANK_W'(1);
                end
              end
              rank[tgt_idx] <= '0;
            end
          end
          OP_OFF: begin
            for (int v = 0; v < C_VOICES; v++) begin
              if (voiceOn[v] && (note_arr[v] == note_q)) begin
                voiceOn[v] <= 1'b0;
              end
            end
          end
          OP_ALL: begin
            voiceOn <= '0;
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Flatten the per-voice note registers onto the packed output bus.
  for (genvar g = 0; g < C_VOICES; g++) begin : g_note_out
    assign voiceNote[g*C_NOTE_WIDTH +: C_NOTE_WIDTH] = note_arr[g];
  end

endmodule

// File: tb/tb_note_voice_alloc.sv
// tb_note_voice_alloc: directed scenarios for the note command decoder and voice allocator.
module tb_note_voice_alloc;

  localparam int TIMEOUT = 100;

  logic        clk;
  logic        rstb;
  logic        rxValid;
  logic        rxAck;
  logic [7:0]  rxData;
  logic        rxErr;
  logic [3:0]  voiceOn;
  logic [27:0] voiceNote;
  logic [3:0]  voiceTrig;
  logic        cmdErr;

  int errors;
  int checks;

  note_voice_alloc #(
    .C_DATA_WIDTH(8),
    .C_VOICES    (4),
    .C_NOTE_WIDTH(7),
    .C_TIMEOUT   (TIMEOUT)
  ) dut (
    .clk      (clk),
    .rstb     (rstb),
    .rxValid  (rxValid),
    .rxAck    (rxAck),
    .rxData   (rxData),
    .rxErr    (rxErr),
    .voiceOn  (voiceOn),
    .voiceNote(voiceNote),
    .voiceTrig(voiceTrig),
    .cmdErr   (cmdErr)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Global safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  function automatic logic [6:0] note_of(input int v);
    return voiceNote[v*7 +: 7];
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rstb    = 1'b0;
    rxValid = 1'b0;
    rxErr   = 1'b0;
    rxData  = 8'h00;
    repeat (2) @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);
  endtask

  // Present one word, wait for the ack, then withdraw it; returns in the cycle after the ack.
  task automatic send_byte(input logic [7:0] b, input logic e);
    bit got;
    @(negedge clk);
    rxValid = 1'b1;
    rxData  = b;
    rxErr   = e;
    got     = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (rxAck === 1'b1) got = 1'b1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("[TB] FAIL ack_wait byte=%h: got no rxAck, required rxAck within 10 cycles", b);
    end
    @(negedge clk);
    rxValid = 1'b0;
    rxErr   = 1'b0;
    checks++;
    if (rxAck !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ack_single byte=%h: got rxAck=%b, required 0", b, rxAck);
    end
  endtask

  // Full note-on command; returns in the cycle the voice outputs first show the result.
  task automatic note_on(input logic [6:0] n);
    send_byte(8'h90, 1'b0);
    send_byte({1'b0, n}, 1'b0);
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (voiceOn !== 4'b0000) begin errors++; $display("[TB] FAIL reset_on: got %b, required 0000", voiceOn); end
    checks++;
    if (voiceNote !== 28'h0) begin errors++; $display("[TB] FAIL reset_note: got %h, required 0", voiceNote); end
    checks++;
    if ({voiceTrig, cmdErr, rxAck} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL reset_pulses: got trig=%b err=%b ack=%b, required all 0", voiceTrig, cmdErr, rxAck);
    end
  endtask

  task automatic test_first_note();
    do_reset();
    send_byte(8'h90, 1'b0);
    send_byte(8'h3C, 1'b0);
    checks++;
    if (voiceOn !== 4'b0000 || cmdErr !== 1'b0) begin
      errors++;
      $display("[TB] FAIL first_early: got on=%b err=%b, required on=0000 err=0", voiceOn, cmdErr);
    end
    @(negedge clk);
    checks++;
    if (voiceOn !== 4'b0001) begin errors++; $display("[TB] FAIL first_on: got %b, required 0001", voiceOn); end
    checks++;
    if (note_of(0) !== 7'h3C) begin errors++; $display("[TB] FAIL first_note: got %h, required 3c", note_of(0)); end
    checks++;
    if (voiceTrig !== 4'b0001) begin errors++; $display("[TB] FAIL first_trig: got %b, required 0001", voiceTrig); end
    @(negedge clk);
    checks++;
    if (voiceTrig !== 4'b0000) begin errors++; $display("[TB] FAIL first_trig_end: got %b, required 0000", voiceTrig); end
  endtask

  task automatic test_steal();
    logic [6:0] notes [4];
    notes[0] = 7'h3C; notes[1] = 7'h40; notes[2] = 7'h43; notes[3] = 7'h47;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      note_on(notes[i]);
      checks++;
      if (voiceTrig !== 4'(1 << i) || note_of(i) !== notes[i]) begin
        errors++;
        $display("[TB] FAIL alloc_%0d: got trig=%b note=%h, required trig=%b note=%h",
                 i, voiceTrig, note_of(i), 4'(1 << i), notes[i]);
      end
    end
    note_on(7'h48);
    checks++;
    if (voiceOn !== 4'b1111) begin errors++; $display("[TB] FAIL steal_on: got %b, required 1111", voiceOn); end
    checks++;
    if (voiceTrig !== 4'b0001) begin errors++; $display("[TB] FAIL steal_trig: got %b, required 0001", voiceTrig); end
    checks++;
    if (note_of(0) !== 7'h48 || note_of(1) !== 7'h40) begin
      errors++;
      $display("[TB] FAIL steal_note: got v0=%h v1=%h, required v0=48 v1=40", note_of(0), note_of(1));
    end
  endtask

  task automatic test_retrigger();
    do_reset();
    note_on(7'h3C);
    note_on(7'h3C);
    checks++;
    if (voiceTrig !== 4'b0001 || voiceOn !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL retrig: got trig=%b on=%b, required trig=0001 on=0001", voiceTrig, voiceOn);
    end
    send_byte(8'h80, 1'b0);
    send_byte(8'h3C, 1'b0);
    @(negedge clk);
    checks++;
    if (voiceOn !== 4'b0000 || voiceTrig !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL note_off: got on=%b trig=%b, required on=0000 trig=0000", voiceOn, voiceTrig);
    end
    checks++;
    if (note_of(0) !== 7'h3C) begin errors++; $display("[TB] FAIL off_keeps_note: got %h, required 3c", note_of(0)); end
    note_on(7'h40);
    send_byte(8'h80, 1'b0);
    send_byte(8'h55, 1'b0);
    checks++;
    if (cmdErr !== 1'b0) begin errors++; $display("[TB] FAIL off_nomatch_err: got %b, required 0", cmdErr); end
    @(negedge clk);
    checks++;
    if (voiceOn !== 4'b0001 || note_of(0) !== 7'h40 || voiceTrig !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL off_nomatch: got on=%b v0=%h trig=%b, required on=0001 v0=40 trig=0000",
               voiceOn, note_of(0), voiceTrig);
    end
  endtask

  task automatic test_retrigger_rank();
    do_reset();
    note_on(7'h3C);
    note_on(7'h40);
    note_on(7'h43);
    note_on(7'h47);
    note_on(7'h3C);
    checks++;
    if (voiceTrig !== 4'b0001 || voiceOn !== 4'b1111) begin
      errors++;
      $display("[TB] FAIL full_retrig: got trig=%b on=%b, required trig=0001 on=1111", voiceTrig, voiceOn);
    end
    note_on(7'h48);
    checks++;
    if (voiceTrig !== 4'b0001 || note_of(0) !== 7'h48) begin
      errors++;
      $display("[TB] FAIL retrig_rank: got trig=%b v0=%h, required trig=0001 v0=48", voiceTrig, note_of(0));
    end
  endtask

  task automatic test_timeout();
    bit got;
    int k;
    do_reset();
    note_on(7'h30);
    send_byte(8'h90, 1'b0);
    got = 1'b0;
    k   = 0;
    for (int i = 1; i <= 2 * TIMEOUT && !got; i++) begin
      @(negedge clk);
      if (cmdErr === 1'b1) begin
        got = 1'b1;
        k   = i;
      end
    end
    checks++;
    if (k != TIMEOUT) begin
      errors++;
      $display("[TB] FAIL timeout_cycle: got cmdErr after %0d cycles, required %0d", k, TIMEOUT);
    end
    @(negedge clk);
    checks++;
    if (cmdErr !== 1'b0) begin errors++; $display("[TB] FAIL timeout_pulse: got %b, required 0", cmdErr); end
    send_byte(8'h3C, 1'b0);
    checks++;
    if (cmdErr !== 1'b1) begin errors++; $display("[TB] FAIL stray_data_err: got %b, required 1", cmdErr); end
    @(negedge clk);
    checks++;
    if (voiceOn !== 4'b0001 || note_of(0) !== 7'h30 || voiceTrig !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL stray_data_voice: got on=%b v0=%h trig=%b, required on=0001 v0=30 trig=0000",
               voiceOn, note_of(0), voiceTrig);
    end
  endtask

  task automatic test_resync_and_rxerr();
    do_reset();
    note_on(7'h50);
    note_on(7'h51);
    send_byte(8'h90, 1'b0);
    send_byte(8'hB0, 1'b0);
    checks++;
    if (cmdErr !== 1'b1) begin errors++; $display("[TB] FAIL resync_err: got %b, required 1", cmdErr); end
    @(negedge clk);
    checks++;
    if (voiceOn !== 4'b0000 || voiceTrig !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL all_off: got on=%b trig=%b, required on=0000 trig=0000", voiceOn, voiceTrig);
    end
    checks++;
    if (note_of(0) !== 7'h50 || note_of(1) !== 7'h51) begin
      errors++;
      $display("[TB] FAIL all_off_notes: got v0=%h v1=%h, required v0=50 v1=51", note_of(0), note_of(1));
    end
    send_byte(8'h90, 1'b1);
    checks++;
    if (cmdErr !== 1'b1) begin errors++; $display("[TB] FAIL rxerr_idle: got %b, required 1", cmdErr); end
    send_byte(8'h3C, 1'b0);
    checks++;
    if (cmdErr !== 1'b1) begin errors++; $display("[TB] FAIL rxerr_idle_state: got %b, required 1", cmdErr); end
    send_byte(8'h90, 1'b0);
    send_byte(8'h3C, 1'b1);
    checks++;
    if (cmdErr !== 1'b1) begin errors++; $display("[TB] FAIL rxerr_wait: got %b, required 1", cmdErr); end
    @(negedge clk);
    checks++;
    if (voiceOn !== 4'b0000 || voiceTrig !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL rxerr_wait_voice: got on=%b trig=%b, required on=0000 trig=0000", voiceOn, voiceTrig);
    end
    send_byte(8'h3C, 1'b0);
    checks++;
    if (cmdErr !== 1'b1) begin errors++; $display("[TB] FAIL rxerr_wait_state: got %b, required 1", cmdErr); end
  endtask

  task automatic test_reset_mid_command();
    do_reset();
    note_on(7'h3C);
    note_on(7'h40);
    note_on(7'h43);
    checks++;
    if (voiceOn !== 4'b0111) begin errors++; $display("[TB] FAIL pre_reset_on: got %b, required 0111", voiceOn); end
    send_byte(8'h90, 1'b0);
    #2;
    rstb = 1'b0;
    #1;
    checks++;
    if (voiceOn !== 4'b0000 || voiceNote !== 28'h0 || voiceTrig !== 4'b0000 || cmdErr !== 1'b0 || rxAck !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_reset: got on=%b note=%h trig=%b err=%b ack=%b, required all 0",
               voiceOn, voiceNote, voiceTrig, cmdErr, rxAck);
    end
    repeat (2) @(negedge clk);
    rstb = 1'b1;
    send_byte(8'h3C, 1'b0);
    checks++;
    if (cmdErr !== 1'b1) begin errors++; $display("[TB] FAIL reset_discard: got %b, required 1", cmdErr); end
    @(negedge clk);
    checks++;
    if (voiceOn !== 4'b0000) begin errors++; $display("[TB] FAIL reset_discard_on: got %b, required 0000", voiceOn); end
    note_on(7'h3C);
    note_on(7'h40);
    note_on(7'h43);
    note_on(7'h47);
    note_on(7'h48);
    checks++;
    if (voiceTrig !== 4'b0001 || note_of(0) !== 7'h48) begin
      errors++;
      $display("[TB] FAIL post_reset_steal: got trig=%b v0=%h, required trig=0001 v0=48", voiceTrig, note_of(0));
    end
  endtask

  // Scenario sequence.
  initial begin
    errors  = 0;
    checks  = 0;
    rstb    = 1'b0;
    rxValid = 1'b0;
    rxErr   = 1'b0;
    rxData  = 8'h00;
    test_reset();
    test_first_note();
    test_steal();
    test_retrigger();
    test_retrigger_rank();
    test_timeout();
    test_resync_and_rxerr();
    test_reset_mid_command();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/note_voice_alloc.md
NOTE_VOICE_ALLOC -- requirements
Module: note_voice_alloc

Interface
REQ-001 SHALL have parameter C_DATA_WIDTH, default 8: UART word width in bits; fixed at 8 for command decoding.
REQ-002 SHALL have parameter C_VOICES, default 4: number of polyphonic voice channels, legal range 2..16.
REQ-003 SHALL have parameter C_NOTE_WIDTH, default 7: note code width in bits.
REQ-004 SHALL have parameter C_TIMEOUT, default 1_000_000: maximum clk cycles allowed between a status byte and its data byte.
REQ-005 SHALL have port clk, input, 1 bit: single system clock; all logic on its rising edge.
REQ-006 SHALL have port rstb, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port rxValid, input, 1 bit: a UART Rx word is pending.
REQ-008 SHALL have port rxAck, output, 1 bit: one-cycle consume pulse back to UART Rx.
REQ-009 SHALL have port rxData, input, C_DATA_WIDTH bits: the received word.
REQ-010 SHALL have port rxErr, input, 1 bit: framing/parity error flag on the pending word.
REQ-011 SHALL have port voiceOn, output, C_VOICES bits: bit v is high while voice v holds a note.
REQ-012 SHALL have port voiceNote, output, C_VOICES*C_NOTE_WIDTH bits: voice v note at [v*C_NOTE_WIDTH +: C_NOTE_WIDTH].
REQ-013 SHALL have port voiceTrig, output, C_VOICES bits: one-cycle pulse on bit v when voice v is (re)assigned.
REQ-014 SHALL have port cmdErr, output, 1 bit: one-cycle pulse on a protocol error.

Function
REQ-015 SHALL decode status bytes as follows: 0x90 note-on, 0x80 note-off, 0xB0 all-off; any other byte with MSB=1 is illegal; a byte with MSB=0 is a data byte carrying note[6:0].
REQ-016 SHALL implement the FSM states IDLE, WAIT_NOTE and APPLY.
REQ-017 SHALL assert rxAck for exactly one cycle, in the cycle after rxValid is sampled high in IDLE or WAIT_NOTE, and SHALL sample the word in that cycle.
REQ-018 SHALL keep rxAck low in APPLY and SHALL never assert it on consecutive cycles.
REQ-019 SHALL handle IDLE words as follows: 0x90/0x80 -> WAIT_NOTE with the opcode latched; 0xB0 -> APPLY (all-off); a data byte or an illegal byte -> cmdErr pulse, stay IDLE.
REQ-020 SHALL handle WAIT_NOTE words as follows: a data byte -> note latched, APPLY; a status byte -> cmdErr pulse, then reprocess that byte as in IDLE (running resync).
REQ-021 SHALL, on a word with rxErr=1 in any state, consume the word, pulse cmdErr and go to IDLE.
REQ-022 SHALL count clk cycles in WAIT_NOTE and, on reaching C_TIMEOUT without a word, pulse cmdErr and go to IDLE.
REQ-023 SHALL spend exactly one cycle in APPLY; voice outputs SHALL update on the edge ending APPLY, i.e. visible 2 cycles after the data-byte ack cycle.
REQ-024 SHALL apply note-on as follows: if any on voice holds the note -> retrigger the lowest such voice (voiceTrig pulse, no reallocation); else allocate the lowest-index free voice; if none is free -> steal the oldest voice.
REQ-025 SHALL keep a per-voice age rank 0..C_VOICES-1, unique across voices: on allocate/steal of voice v, every voice with rank < rank[v] SHALL increment and rank[v] SHALL become 0; oldest = rank C_VOICES-1.
REQ-026 SHALL apply note-off by clearing voiceOn for every voice holding the note; voiceNote SHALL be retained; a note-off with no match SHALL produce no output change and no error.
REQ-027 SHALL apply all-off by clearing all voiceOn bits in one cycle; ranks and voiceNote SHALL be unchanged.
REQ-028 SHALL assert voiceTrig coincident with the voiceOn/voiceNote update; note-off and all-off SHALL never pulse it.
REQ-029 SHALL register all outputs, with no combinational path from input to output.

Reset
REQ-030 SHALL, on rstb low, immediately set: FSM to IDLE, rxAck=0, voiceOn=0, voiceNote=0, voiceTrig=0, cmdErr=0, timeout counter=0, rank[v]=v.
REQ-031 SHALL discard a partially received command when reset asserts mid-command; after release, the next byte SHALL be decoded as in IDLE.

Verification
REQ-032 SHALL be verified as follows: after reset, send 0x90,0x3C -> 2 cycles after the second ack: voiceOn=0001, voice0 note=0x3C, voiceTrig=0001 for 1 cycle.
REQ-033 SHALL be verified as follows: send note-on 0x3C,0x40,0x43,0x47 then 0x90,0x48 -> voice0 (oldest) stolen, note 0x48, voiceOn=1111, voiceTrig=0001.
REQ-034 SHALL be verified as follows: with 0x3C held on voice0, send 0x90,0x3C -> voiceTrig=0001, voiceOn and ranks unchanged; then 0x80,0x3C -> voiceOn bit0=0, voiceNote[0] still 0x3C.
REQ-035 SHALL be verified as follows: send 0x90 then idle C_TIMEOUT cycles (C_TIMEOUT=100) -> cmdErr pulse at cycle 100, FSM IDLE; next 0x3C alone -> cmdErr, no voice change.
REQ-036 SHALL be verified as follows: send 0x90 then 0xB0 -> cmdErr pulse, then all-off applied; a word with rxErr=1 -> acked, cmdErr, IDLE.
REQ-037 SHALL be verified as follows: with 3 voices on, assert rstb low mid-WAIT_NOTE -> all outputs 0 asynchronously, ranks = index.
